control_multiciclo: RTL and testbench
=====================================

CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 opcode  in  6  instr[31:26] from the instruction register; sampled in DECODE only.
REQ-004 mem_ready  in  1  memory handshake; high = current memory access completes this cycle.
REQ-005 pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write  out  1 each  datapath strobes.
REQ-006 i_or_d, mem_to_reg, reg_dst, alu_src_a  out  1 each  datapath mux selects.
REQ-007 alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-008 pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 alu_op  out  3  ALU-control code: 000 add, 001 sub, 010 R-type, 011 addi, 100 ori, 101 andi, 110 slti.
REQ-010 state  out  4  current state encoding, for debug.
REQ-011 illegal  out  1  sticky unsupported-opcode flag.

Function
REQ-012 Moore FSM with states: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, I_EXEC=9, I_WB=10, JUMP=11; codes 12-15 are unused and go to FETCH next cycle.
REQ-013 Every output not listed for a state is 0 in that state.
REQ-014 FETCH: mem_read=1, alu_src_b=01, alu_op=000; ir_write=pc_write=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-015 DECODE: alu_src_b=11, alu_op=000; next by opcode: 100011/101011 -> MEM_ADDR, 000000 -> R_EXEC, 000100 -> BRANCH, 001000/001101/001100/001010 -> I_EXEC, anything else -> FETCH with illegal set.
REQ-016 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000; next MEM_READ if the DECODE opcode was 100011, else MEM_WRITE.
REQ-017 MEM_READ: mem_read=1, i_or_d=1; hold until mem_ready=1, then MEM_WB.
REQ-018 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-019 MEM_WRITE: mem_write=1, i_or_d=1; hold until mem_ready=1, then FETCH.
REQ-020 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010; next R_WB. R_WB: reg_write=1, reg_dst=1; next FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01; next FETCH.
REQ-022 I_EXEC: alu_src_a=1, alu_src_b=10; alu_op 011/100/101/110 for opcode 001000/001101/001100/001010; next I_WB. I_WB: reg_write=1, reg_dst=0; next FETCH.
REQ-023 Opcode is registered on the DECODE->next transition; opcode changes in later states have no effect.
REQ-024 Cycle counts with mem_ready always 1: lw 5, sw 4, R-type 4, I-type 4, beq 3; each cycle of mem_ready=0 in FETCH/MEM_READ/MEM_WRITE adds exactly one cycle.
REQ-025 illegal is set on the clock edge leaving DECODE with an unsupported opcode, stays 1 until reset, and does not stall the FSM.

Reset
REQ-026 rst_n low: state=FETCH and illegal=0 immediately, independent of clk; stored opcode cleared to 000000.
REQ-027 While rst_n is low, all strobes (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write) are forced to 0; the selects take their FETCH values.
REQ-028 Reset asserted mid-instruction (including during a memory stall) abandons the instruction; the first edge after release performs FETCH.

Configuration
REQ-029 Macro JUMP_INSTR_EN: when defined, opcode 000010 goes DECODE -> JUMP, where pc_write=1 and pc_source=10, then FETCH (3 cycles total); when undefined, JUMP is unreachable and 000010 is treated as illegal.

Verification
REQ-030 Reset release, mem_ready=1, opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in cycle 5.
REQ-031 opcode=000000, mem_ready=0 for 2 cycles in FETCH -> FETCH held 3 cycles, then 1,6,7; alu_op=010 in R_EXEC.
REQ-032 opcode=001101 -> alu_op=100 in I_EXEC; opcode=001010 -> alu_op=110; both end in I_WB with reg_dst=0 and reg_write=1.
REQ-033 opcode=000100 -> BRANCH with pc_write_cond=1, alu_op=001, pc_source=01; FETCH on the next cycle.
REQ-034 opcode=111111 -> illegal=1 after DECODE and the FSM returns to FETCH; illegal stays 1 until rst_n is pulsed low.
REQ-035 opcode=101011, rst_n pulsed low during a MEM_WRITE stall -> mem_write=0 immediately and state=0; the next sequence starts at FETCH.

Source files
------------

// File: rtl/control_multiciclo.sv
// rtl/control_multiciclo.sv - multicycle MIPS-subset control FSM with memory handshake.
// Optional JUMP state enabled by defining JUMP_INSTR_EN.
module control_multiciclo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       i_or_d,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
`ifdef JUMP_INSTR_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  state_t     r_state;
  logic [5:0] r_opcode;
  logic       r_illegal;

  logic w_pc_write, w_pc_write_cond, w_ir_write, w_mem_read, w_mem_write, w_reg_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_opcode  <= 6'b000000;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:     if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          // Later states only look at the copy captured here.
          r_opcode <= opcode;
          case (opcode)
            OP_LW, OP_SW:                     r_state <= S_MEM_ADDR;
            OP_RTYPE:                         r_state <= S_R_EXEC;
            OP_BEQ:                           r_state <= S_BRANCH;
            OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI: r_state <= S_I_EXEC;
`ifdef JUMP_INSTR_EN
            OP_J:                             r_state <= S_JUMP;
`endif
            default: begin
              r_state   <= S_FETCH;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEM_ADDR:  r_state <= (r_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WB:    r_state <= S_FETCH;
        S_MEM_WRITE: if (mem_ready) r_state <= S_FETCH;
        S_R_EXEC:    r_state <= S_R_WB;
        S_R_WB:      r_state <= S_FETCH;
        S_BRANCH:    r_state <= S_FETCH;
        S_I_EXEC:    r_state <= S_I_WB;
        S_I_WB:      r_state <= S_FETCH;
        S_JUMP:      r_state <= S_FETCH;
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_reg_write     = 1'b0;
    i_or_d          = 1'b0;
    mem_to_reg      = 1'b0;
    reg_dst         = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    pc_source       = 2'b00;
    alu_op          = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        alu_src_b  = 2'b01;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
      end
      S_DECODE:    alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        w_mem_read = 1'b1;
        i_or_d     = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEM_WRITE: begin
        w_mem_write = 1'b1;
        i_or_d      = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_R_WB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        alu_op          = 3'b001;
        w_pc_write_cond = 1'b1;
        pc_source       = 2'b01;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (r_opcode)
          OP_ADDI: alu_op = 3'b011;
          OP_ORI:  alu_op = 3'b100;
          OP_ANDI: alu_op = 3'b101;
          OP_SLTI: alu_op = 3'b110;
          default: alu_op = 3'b000;
        endcase
      end
      S_I_WB:      w_reg_write = 1'b1;
      S_JUMP: begin
        w_pc_write = 1'b1;
        pc_source  = 2'b10;
      end
      default: ;
    endcase
  end

  // Strobes are killed combinationally so a held reset never writes the datapath.
  assign pc_write      = w_pc_write      & rst_n;
  assign pc_write_cond = w_pc_write_cond & rst_n;
  assign ir_write      = w_ir_write      & rst_n;
  assign mem_read      = w_mem_read      & rst_n;
  assign mem_write     = w_mem_write     & rst_n;
  assign reg_write     = w_reg_write     & rst_n;

  assign state   = r_state;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_control_multiciclo.sv
// tb/tb_control_multiciclo.sv - scoreboard bench for control_multiciclo.
// Expected per-cycle outputs come from an instruction-level path model.
module tb_control_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
  logic       i_or_d, mem_to_reg, reg_dst, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic       illegal;

  control_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op),
    .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, ANDI = 6'b001100, SLTI = 6'b001010;
  localparam logic [5:0] JMP = 6'b000010;

  logic [21:0] q[$];
  int checks = 0;
  int failures = 0;
  logic       m_ill;
  logic [5:0] m_sop;

  function automatic logic [21:0] exp_vec(int st, logic [5:0] sop, logic mr, logic ill, logic in_rst);
    logic pw = 0, pwc = 0, irw = 0, mrd = 0, mwr = 0, rw = 0;
    logic iod = 0, m2r = 0, rd = 0, asa = 0;
    logic [1:0] asb = 0, pcs = 0;
    logic [2:0] aop = 0;
    case (st)
      0:  begin mrd = 1; asb = 2'd1; irw = mr; pw = mr; end
      1:  asb = 2'd3;
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin asa = 1; aop = 3'd2; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 3'd1; pwc = 1; pcs = 2'd1; end
      9:  begin
            asa = 1; asb = 2'd2;
            if (sop == ADDI) aop = 3'd3;
            else if (sop == ORI) aop = 3'd4;
            else if (sop == ANDI) aop = 3'd5;
            else aop = 3'd6;
          end
      10: rw = 1;
      11: begin pw = 1; pcs = 2'd2; end
      default: ;
    endcase
    if (in_rst) begin
      pw = 0; pwc = 0; irw = 0; mrd = 0; mwr = 0; rw = 0;
    end
    return {st[3:0], ill, pw, pwc, irw, mrd, mwr, rw, iod, m2r, rd, asa, asb, pcs, aop};
  endfunction

  // 0 illegal, 1 lw, 2 sw, 3 R, 4 beq, 5 I-type, 6 jump
  function automatic int classify(logic [5:0] op);
    if (op == LW) return 1;
    if (op == SW) return 2;
    if (op == RT) return 3;
    if (op == BEQ) return 4;
    if (op == ADDI || op == ORI || op == ANDI || op == SLTI) return 5;
`ifdef JUMP_INSTR_EN
    if (op == JMP) return 6;
`endif
    return 0;
  endfunction

  task automatic step(int st, logic mr, logic [5:0] opc);
    rst_n = 1'b1;
    mem_ready = mr;
    opcode = opc;
    q.push_back(exp_vec(st, m_sop, mr, m_ill, 1'b0));
    @(posedge clk); #1;
  endtask

  task automatic rst_cycle();
    rst_n = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    opcode = 6'($urandom);
    m_ill = 1'b0;
    m_sop = 6'b000000;
    q.push_back(exp_vec(0, m_sop, mem_ready, 1'b0, 1'b1));
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One instruction: FETCH stalls sf cycles, memory stalls sm cycles;
  // rst_at >= 0 replaces memory cycle rst_at with a reset pulse.
  task automatic run_instr(logic [5:0] opc, int sf, int sm, int rst_at);
    int kind;
    int ms;
    kind = classify(opc);
    for (int k = 0; k < sf; k++) step(0, 1'b0, 6'($urandom));
    step(0, 1'b1, 6'($urandom));
    step(1, 1'($urandom_range(0, 1)), opc);
    m_sop = opc;
    if (kind == 0) begin
      m_ill = 1'b1;
      return;
    end
    case (kind)
      1, 2: begin
        step(2, 1'($urandom_range(0, 1)), 6'($urandom));
        ms = (kind == 1) ? 3 : 5;
        for (int k = 0; k <= sm; k++) begin
          if (k == rst_at) begin
            rst_cycle();
            return;
          end
          step(ms, (k == sm), 6'($urandom));
        end
        if (kind == 1) step(4, 1'($urandom_range(0, 1)), 6'($urandom));
      end
      3: begin
        step(6, 1'($urandom_range(0, 1)), 6'($urandom));
        step(7, 1'($urandom_range(0, 1)), 6'($urandom));
      end
      4: step(8, 1'($urandom_range(0, 1)), 6'($urandom));
      5: begin
        step(9, 1'($urandom_range(0, 1)), 6'($urandom));
        step(10, 1'($urandom_range(0, 1)), 6'($urandom));
      end
      default: step(11, 1'($urandom_range(0, 1)), 6'($urandom));
    endcase
  endtask

  always @(negedge clk) begin
    logic [21:0] e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {state, illegal, pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write,
           i_or_d, mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_source, alu_op};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs t=%0t state=%0d actual=%h required=%h", $time, e[21:18], a, e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops [0:9];
    logic [5:0] op;
    int sm;
    int ra;
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ; ops[4] = ADDI;
    ops[5] = ORI; ops[6] = ANDI; ops[7] = SLTI; ops[8] = JMP; ops[9] = 6'b111111;
    m_ill = 1'b0;
    m_sop = 6'b000000;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = LW;
    repeat (2) @(posedge clk);
    #1;
    rst_cycle();

    run_instr(LW, 0, 0, -1);
    run_instr(RT, 2, 0, -1);
    run_instr(ORI, 0, 0, -1);
    run_instr(SLTI, 0, 0, -1);
    run_instr(BEQ, 0, 0, -1);
    run_instr(6'b111111, 0, 0, -1);
    run_instr(LW, 1, 1, -1);
    run_instr(ADDI, 0, 0, -1);
    rst_cycle();
    run_instr(SW, 0, 2, 1);
    run_instr(SW, 0, 1, -1);
    run_instr(JMP, 0, 0, -1);
    run_instr(ANDI, 1, 1, -1);

    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      sm = $urandom_range(0, 2);
      ra = ($urandom_range(0, 9) == 0) ? $urandom_range(0, sm) : -1;
      run_instr(op, $urandom_range(0, 2), sm, ra);
      if ($urandom_range(0, 11) == 0) rst_cycle();
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
